// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared register-file types for the writeback path
package rv32i_pkg;

  localparam int NumRegs = 32;

  typedef logic [4:0]  reg_addr_t;
  typedef logic [31:0] xlen_t;

  typedef struct packed {
    reg_addr_t rd;
    xlen_t     data;
  } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - small synchronous FIFO of writeback requests
module wb_fifo
  import rv32i_pkg::*;
#(
  parameter int Depth = 2,
  localparam int PtrW = $clog2(Depth),
  localparam int CntW = $clog2(Depth + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  wb_req_t         push_data,
  input  logic            pop,
  output wb_req_t         head,
  output logic            full,
  output logic            empty,
  output logic [CntW-1:0] count
);

  wb_req_t         r_mem [Depth];
  logic [PtrW-1:0] r_wr_ptr;
  logic [PtrW-1:0] r_rd_ptr;
  logic [CntW-1:0] r_count;
  logic            w_do_push;
  logic            w_do_pop;

  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  // Storage is not reset; the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_do_push && w_do_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  assign full  = (r_count == CntW'(Depth));
  assign empty = (r_count == '0);
  assign count = r_count;
  assign head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/regfile_wb_scheduler.sv
// rtl/regfile_wb_scheduler.sv - arbitrates the register file write port between EX and LSU
// and tracks long-latency destinations in a busy scoreboard.
module regfile_wb_scheduler
  import rv32i_pkg::*;
#(
  parameter int DataWidth   = 32,
  parameter int RegAddress  = 5,
  parameter int LsuQDepth   = 2,
  parameter int StarveLimit = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_valid,
  input  logic [RegAddress-1:0] ex_rd,
  input  logic [DataWidth-1:0]  ex_data,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [RegAddress-1:0] lsu_rd,
  input  logic [DataWidth-1:0]  lsu_data,
  input  logic                  sb_set,
  input  logic [RegAddress-1:0] sb_set_rd,
  input  logic [RegAddress-1:0] iss_rs1,
  input  logic [RegAddress-1:0] iss_rs2,
  input  logic [RegAddress-1:0] iss_rd,
  output logic                  hazard_stall,
  output logic                  starve_stall,
  output logic                  rf_write_enable,
  output logic [RegAddress-1:0] rf_write_addr,
  output logic [DataWidth-1:0]  rf_write_data
);

  localparam int NumEntries = 2 ** RegAddress;
  localparam int StarveW    = $clog2(StarveLimit + 1);
  localparam int QCntW      = $clog2(LsuQDepth + 1);

  wb_req_t               w_push_req;
  wb_req_t               w_head;
  logic                  w_full;
  logic                  w_empty;
  logic [QCntW-1:0]      w_count;
  logic                  w_push;
  logic                  w_pop;
  logic [RegAddress-1:0] w_sel_rd;
  logic [DataWidth-1:0]  w_sel_data;
  logic [NumEntries-1:0] r_busy;
  logic [NumEntries-1:0] w_busy_nxt;
  logic [StarveW-1:0]    r_starve_cnt;
  logic [StarveW-1:0]    w_starve_nxt;

  // Writes to x0 are accepted on the handshake but never enqueued.
  assign w_push          = lsu_valid && !w_full && (lsu_rd != '0);
  assign w_push_req.rd   = lsu_rd;
  assign w_push_req.data = lsu_data;

  wb_fifo #(
    .Depth(LsuQDepth)
  ) u_lsu_q (
    .clk      (clk),
    .rst      (rst),
    .push     (w_push),
    .push_data(w_push_req),
    .pop      (w_pop),
    .head     (w_head),
    .full     (w_full),
    .empty    (w_empty),
    .count    (w_count)
  );

  assign lsu_ready  = !w_full;
  assign w_pop      = !ex_valid && !w_empty;
  assign w_sel_rd   = ex_valid ? ex_rd : w_head.rd;
  assign w_sel_data = ex_valid ? ex_data : w_head.data;

  assign rf_write_enable = rst && (ex_valid || !w_empty) && (w_sel_rd != '0);
  assign rf_write_addr   = w_sel_rd;
  assign rf_write_data   = w_sel_data;

  // A new long-latency dispatch must win over the retiring write to the same register.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_pop) w_busy_nxt[w_head.rd] = 1'b0;
    if (sb_set) w_busy_nxt[sb_set_rd] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_comb begin
    w_starve_nxt = '0;
    if (ex_valid && (w_count != '0)) begin
      w_starve_nxt = starve_stall ? r_starve_cnt : r_starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy       <= '0;
      r_starve_cnt <= '0;
    end else begin
      r_busy       <= w_busy_nxt;
      r_starve_cnt <= w_starve_nxt;
    end
  end

  assign hazard_stall = r_busy[iss_rs1] | r_busy[iss_rs2] | r_busy[iss_rd];
  assign starve_stall = (r_starve_cnt == StarveW'(StarveLimit));

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// tb/tb_regfile_wb_scheduler.sv - directed vector bench for regfile_wb_scheduler
module tb_regfile_wb_scheduler;

  typedef struct {
    logic        exv;
    logic [4:0]  exrd;
    logic [31:0] exd;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ld;
    logic        sbs;
    logic [4:0]  sbrd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        rdy;
    logic        hz;
    logic        st;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic [4:0]  ex_rd;
  logic [31:0] ex_data;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        sb_set;
  logic [4:0]  sb_set_rd;
  logic [4:0]  iss_rs1;
  logic [4:0]  iss_rs2;
  logic [4:0]  iss_rd;
  logic        hazard_stall;
  logic        starve_stall;
  logic        rf_write_enable;
  logic [4:0]  rf_write_addr;
  logic [31:0] rf_write_data;

  int n_pass;
  int n_total;
  vec_t vecs[24];

  regfile_wb_scheduler dut (
    .clk            (clk),
    .rst            (rst),
    .ex_valid       (ex_valid),
    .ex_rd          (ex_rd),
    .ex_data        (ex_data),
    .lsu_valid      (lsu_valid),
    .lsu_ready      (lsu_ready),
    .lsu_rd         (lsu_rd),
    .lsu_data       (lsu_data),
    .sb_set         (sb_set),
    .sb_set_rd      (sb_set_rd),
    .iss_rs1        (iss_rs1),
    .iss_rs2        (iss_rs2),
    .iss_rd         (iss_rd),
    .hazard_stall   (hazard_stall),
    .starve_stall   (starve_stall),
    .rf_write_enable(rf_write_enable),
    .rf_write_addr  (rf_write_addr),
    .rf_write_data  (rf_write_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus protocol checks: never write to or re-dispatch a busy register.
  always @(negedge clk) begin
    if (rst) begin
      assert (!(ex_valid && dut.r_busy[ex_rd])) else $error("protocol: ex_valid to busy x%0d", ex_rd);
      assert (!(sb_set && sb_set_rd != 0 && dut.r_busy[sb_set_rd]))
        else $error("protocol: sb_set on busy x%0d", sb_set_rd);
    end
  end

  function automatic vec_t mk(input logic exv, input logic [4:0] exrd, input logic [31:0] exd,
                              input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                              input logic sbs, input logic [4:0] sbrd,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                              input logic we, input logic [4:0] waddr, input logic [31:0] wdata,
                              input logic rdy, input logic hz, input logic st);
    vec_t v;
    v.exv = exv; v.exrd = exrd; v.exd = exd;
    v.lv = lv; v.lrd = lrd; v.ld = ld;
    v.sbs = sbs; v.sbrd = sbrd;
    v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
    v.we = we; v.waddr = waddr; v.wdata = wdata;
    v.rdy = rdy; v.hz = hz; v.st = st;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input vec_t v);
    ex_valid  = v.exv; ex_rd  = v.exrd; ex_data  = v.exd;
    lsu_valid = v.lv;  lsu_rd = v.lrd;  lsu_data = v.ld;
    sb_set    = v.sbs; sb_set_rd = v.sbrd;
    iss_rs1   = v.rs1; iss_rs2 = v.rs2; iss_rd = v.rd;
  endtask

  task automatic check_outs(input string tag, input vec_t v);
    chk({tag, " we"}, {31'd0, rf_write_enable}, {31'd0, v.we});
    if (v.we) begin
      chk({tag, " waddr"}, {27'd0, rf_write_addr}, {27'd0, v.waddr});
      chk({tag, " wdata"}, rf_write_data, v.wdata);
    end
    chk({tag, " ready"}, {31'd0, lsu_ready}, {31'd0, v.rdy});
    chk({tag, " hazard"}, {31'd0, hazard_stall}, {31'd0, v.hz});
    chk({tag, " starve"}, {31'd0, starve_stall}, {31'd0, v.st});
  endtask

  initial begin
    vec_t idle;
    n_pass  = 0;
    n_total = 0;
    idle = mk(0,0,0, 0,0,0, 0,0, 0,0,0, 0,0,0, 1,0,0);

    // Busy set, LSU return clears it
    vecs[0]  = mk(0,0,0,         0,0,0,            1,5, 5,0,0, 0,0,0,            1,0,0);
    vecs[1]  = mk(0,0,0,         0,0,0,            0,0, 5,0,0, 0,0,0,            1,1,0);
    vecs[2]  = mk(0,0,0,         1,5,32'hDEADBEEF, 0,0, 5,0,0, 0,0,0,            1,1,0);
    vecs[3]  = mk(0,0,0,         0,0,0,            0,0, 5,0,0, 1,5,32'hDEADBEEF, 1,1,0);
    vecs[4]  = mk(0,0,0,         0,0,0,            0,0, 5,0,0, 0,0,0,            1,0,0);
    // Starvation: EX holds the port for four cycles with one entry waiting
    vecs[5]  = mk(1,1,32'h101,   1,9,32'h99,       0,0, 0,0,0, 1,1,32'h101,      1,0,0);
    vecs[6]  = mk(1,2,32'h102,   0,0,0,            0,0, 0,0,0, 1,2,32'h102,      1,0,0);
    vecs[7]  = mk(1,3,32'h103,   0,0,0,            0,0, 0,0,0, 1,3,32'h103,      1,0,0);
    vecs[8]  = mk(1,4,32'h104,   0,0,0,            0,0, 0,0,0, 1,4,32'h104,      1,0,0);
    vecs[9]  = mk(1,6,32'h106,   0,0,0,            0,0, 0,0,0, 1,6,32'h106,      1,0,0);
    vecs[10] = mk(0,0,0,         0,0,0,            0,0, 0,0,0, 1,9,32'h99,       1,0,1);
    vecs[11] = idle;
    // Fill the queue behind EX, then drain in order
    vecs[12] = mk(1,10,32'hA0,   1,3,32'h11,       0,0, 0,0,0, 1,10,32'hA0,      1,0,0);
    vecs[13] = mk(1,11,32'hB0,   1,4,32'h22,       0,0, 0,0,0, 1,11,32'hB0,      1,0,0);
    vecs[14] = mk(1,12,32'hC0,   0,0,0,            0,0, 0,0,0, 1,12,32'hC0,      0,0,0);
    vecs[15] = mk(0,0,0,         0,0,0,            0,0, 0,0,0, 1,3,32'h11,       0,0,0);
    vecs[16] = mk(0,0,0,         0,0,0,            0,0, 0,0,0, 1,4,32'h22,       1,0,0);
    vecs[17] = idle;
    // x0 handling and set/clear collision on x7
    vecs[18] = mk(1,0,32'h55,    0,0,0,            0,0, 0,0,0, 0,0,0,            1,0,0);
    vecs[19] = mk(0,0,0,         1,0,32'h66,       0,0, 0,0,0, 0,0,0,            1,0,0);
    vecs[20] = idle;
    vecs[21] = mk(0,0,0,         1,7,32'h77,       0,0, 0,0,0, 0,0,0,            1,0,0);
    vecs[22] = mk(0,0,0,         0,0,0,            1,7, 0,7,0, 1,7,32'h77,       1,0,0);
    vecs[23] = mk(0,0,0,         0,0,0,            0,0, 0,7,0, 0,0,0,            1,1,0);

    // Reset state, with EX trying to write during reset
    rst = 1'b0;
    drive(mk(1,3,32'h33, 0,0,0, 0,0, 0,0,0, 0,0,0, 1,0,0));
    #2;
    check_outs("reset", idle);
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive(idle);
    for (int r = 0; r < 32; r += 3) begin
      iss_rs1 = 5'(r); iss_rs2 = 5'(r); iss_rd = 5'(r);
      #1;
      chk($sformatf("post-reset hazard x%0d", r), {31'd0, hazard_stall}, 32'd0);
    end
    drive(idle);

    for (int i = 0; i < 24; i++) begin
      @(posedge clk);
      #1;
      drive(vecs[i]);
      #4;
      check_outs($sformatf("v%0d", i), vecs[i]);
    end

    // Mid-flight reset: two entries queued, x7 and x8 busy
    @(posedge clk); #1;
    drive(mk(1,15,32'hF0, 1,13,32'hD1, 1,8, 0,0,0, 1,15,32'hF0, 1,0,0));
    #4; check_outs("r0", mk(1,15,32'hF0, 1,13,32'hD1, 1,8, 0,0,0, 1,15,32'hF0, 1,0,0));
    @(posedge clk); #1;
    drive(mk(1,16,32'hF1, 1,14,32'hD2, 0,0, 0,0,0, 1,16,32'hF1, 1,0,0));
    #4; check_outs("r1", mk(1,16,32'hF1, 1,14,32'hD2, 0,0, 0,0,0, 1,16,32'hF1, 1,0,0));
    @(posedge clk); #1;
    drive(mk(1,17,32'hF2, 0,0,0, 0,0, 7,8,0, 1,17,32'hF2, 0,1,0));
    #4; check_outs("r2", mk(1,17,32'hF2, 0,0,0, 0,0, 7,8,0, 1,17,32'hF2, 0,1,0));
    rst = 1'b0;
    #1; check_outs("in-reset", mk(0,0,0, 0,0,0, 0,0, 7,8,0, 0,0,0, 1,0,0));
    @(posedge clk); #1;
    rst = 1'b1;
    drive(mk(0,0,0, 0,0,0, 0,0, 7,8,0, 0,0,0, 1,0,0));
    #4; check_outs("released", mk(0,0,0, 0,0,0, 0,0, 7,8,0, 0,0,0, 1,0,0));
    @(posedge clk); #5;
    check_outs("released+1", mk(0,0,0, 0,0,0, 0,0, 7,8,0, 0,0,0, 1,0,0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/regfile_wb_scheduler.md
Name: regfile_wb_scheduler

Overview:
- Shares the register file's single write port between two writers:
  - the in-order EX/WB stage (single-cycle results, no backpressure);
  - the long-latency LSU/multi-cycle unit (valid/ready, buffered).
- Keeps a per-register busy scoreboard for outstanding long-latency destinations.
- Raises a hazard stall to issue for RAW/WAW on busy registers.
- Sits between the pipeline writeback and the register file write port.

Parameters:
- DataWidth, 32, register/data width.
- RegAddress, 5, register address width; 2**RegAddress registers.
- LsuQDepth, 2, LSU result FIFO depth; power of two, at least 2.
- StarveLimit, 4, consecutive cycles the LSU head may lose arbitration before a starvation stall is requested.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- ex_valid  in  1  EX result valid this cycle; has no ready, must be taken.
- ex_rd  in  RegAddress  EX destination register.
- ex_data  in  DataWidth  EX result.
- lsu_valid  in  1  LSU result offered.
- lsu_ready  out  1  LSU result accepted (FIFO not full).
- lsu_rd  in  RegAddress  LSU destination register.
- lsu_data  in  DataWidth  LSU result.
- sb_set  in  1  issue stage dispatches a long-latency op.
- sb_set_rd  in  RegAddress  destination to mark busy.
- iss_rs1  in  RegAddress  issuing instruction source 1.
- iss_rs2  in  RegAddress  issuing instruction source 2.
- iss_rd  in  RegAddress  issuing instruction destination.
- hazard_stall  out  1  issue must hold.
- starve_stall  out  1  pipeline must inject a bubble (ex_valid=0) next cycle.
- rf_write_enable  out  1  to register file write enable.
- rf_write_addr  out  RegAddress  to register file write address.
- rf_write_data  out  DataWidth  to register file write data.

Behaviour:
- Reset (rst=0, async): FIFO empty; all busy bits 0; starvation counter 0.
- Outputs during reset: lsu_ready=1, hazard_stall=0, starve_stall=0, rf_write_enable=0.
- Write port (combinational, zero latency):
  - If ex_valid: write ex_rd/ex_data.
  - Else if FIFO non-empty: write the FIFO head and pop at the clock edge.
  - rf_write_enable is forced 0 when the selected address is 0. A pop still occurs in that case.
- LSU handshake:
  - Transfer when lsu_valid & lsu_ready; entry pushed at the edge.
  - lsu_ready = !full. Not combinationally dependent on lsu_valid or the same-cycle pop.
  - lsu_rd=0 transfers are accepted and dropped (not enqueued).
  - FIFO count range 0..LsuQDepth. Pointers wrap modulo LsuQDepth.
  - Push and pop in the same cycle leave the count unchanged.
- Scoreboard:
  - busy[sb_set_rd] set at the edge when sb_set and sb_set_rd!=0.
  - busy[head rd] cleared at the edge of the cycle its LSU write is performed.
  - Same-cycle set and clear of the same register: set wins.
  - busy[0] is constant 0.
- hazard_stall = busy[iss_rs1] | busy[iss_rs2] | busy[iss_rd], from current registered state, combinational.
  - A register cleared this edge is not stalled on next cycle. The register file read is asynchronous, so the new value is visible.
- Starvation:
  - Counter increments each cycle the FIFO is non-empty and ex_valid=1.
  - Resets to 0 on any LSU pop or when the FIFO is empty. Saturates at StarveLimit.
  - starve_stall is asserted (registered) while counter == StarveLimit.
  - If ex_valid is still asserted while starve_stall=1, EX still wins. This is a protocol violation, covered by assertion only.
- Protocol assertions (bench): ex_valid with busy[ex_rd]=1 never occurs; sb_set on an already-busy register never occurs.
- Reset mid-operation: FIFO contents discarded, scoreboard cleared, no write issued in the reset cycle.

Decomposition:
- Shared package rv32i_pkg:
  - NumRegs = 32.
  - Typedefs reg_addr_t (logic [4:0]) and xlen_t (logic [31:0]).
  - Struct wb_req_t {rd, data}.
- One sub-module: wb_fifo (parameterised sync FIFO of wb_req_t with push/pop/full/empty/count).
  - Scoreboard, arbitration and starvation counter stay in the top.

Test Plan:
- After reset:
  - Expected: all outputs at reset values; lsu_ready=1; hazard_stall=0 for any rs1/rs2/rd.
- sb_set rd=5; two cycles later lsu push rd=5, data 0xDEADBEEF with ex_valid=0:
  - Expected: rf_write_enable=1, addr 5, data 0xDEADBEEF in the push+1 cycle.
  - Expected: busy[5] clears; hazard_stall for iss_rs1=5 is 1 before that and 0 the cycle after.
- ex_valid=1 every cycle with one LSU entry queued:
  - Expected: EX wins 4 cycles; starve_stall=1 on the 5th cycle.
  - Then ex_valid=0: LSU head written, counter returns to 0, starve_stall=0 next cycle.
- Push 2 LSU entries (rd=3 0x11, rd=4 0x22) while ex_valid=1:
  - Expected: lsu_ready=0.
  - Then drop ex_valid: writes occur in order 3 then 4, and lsu_ready rises after the first pop.
- Edge cases on x0 and set/clear collision:
  - ex_valid with ex_rd=0 gives rf_write_enable=0.
  - lsu push rd=0 is accepted and never written.
  - sb_set rd=7 in the same cycle an LSU write to rd=7 pops leaves busy[7]=1.
- Assert rst low mid-flight with 2 entries queued and busy bits set:
  - Expected: FIFO empty, busy all 0, rf_write_enable=0 immediately and after release.
